// File: rtl/beatmap_pkg.sv
// Shared types and helpers for the beatmap player.
// FSM encoding and constant-width math.
package beatmap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RUN,
    DONE
  } state_t;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    while ((longint'(1) << r) < longint'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/beatmap_rom.sv
// Synchronous-read beatmap ROM, one lane pattern per word.
// Contents come from a packed image; word i sits at bits [i*LANES +: LANES].
module beatmap_rom
  import beatmap_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 17,
  parameter int ADDR_W = 13,
  parameter logic [LANES*DEPTH-1:0] INIT_DATA = '0
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [LANES-1:0]  q
);

  // Addresses past the last step read as a rest.
  always_ff @(posedge clk) begin
    q <= '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) q <= INIT_DATA[i*LANES +: LANES];
    end
  end

endmodule

// File: rtl/beatmap_player.sv
// Tempo-driven beatmap sequencer presenting one lane pattern per step
// on a valid/ready output with loop, pause, rest-skip and overrun support.
module beatmap_player
  import beatmap_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 17,
  parameter int ADDR_W = 13,
  parameter int TICKS_PER_STEP = 12500000,
  parameter bit SKIP_RESTS = 1'b1,
  parameter logic [LANES*DEPTH-1:0] INIT_DATA = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic              note_ready,
  output logic [LANES-1:0]  note_data,
  output logic              note_valid,
  output logic [ADDR_W-1:0] note_index,
  output logic              playing,
  output logic              done,
  output logic              overrun,
  output logic [7:0]        loop_count
);

  localparam int TW = clog2(TICKS_PER_STEP);
  localparam logic [TW-1:0] T_LAST = TW'(TICKS_PER_STEP - 1);
  localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(DEPTH - 1);

  state_t state, state_n;
  logic [TW-1:0] timer;
  logic [ADDR_W-1:0] index;
  logic fetch_p, load_p;
  logic [LANES-1:0] rom_q;
  logic tick, wrap, last, rest, accept, finish;

  beatmap_rom #(
    .LANES(LANES),
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .INIT_DATA(INIT_DATA)
  ) u_rom (
    .clk(clk),
    .addr(index),
    .q(rom_q)
  );

  assign playing = (state == FETCH) || (state == RUN);
  assign done = (state == DONE);
  assign tick = playing && !pause;
  assign wrap = tick && (timer == T_LAST);
  assign last = (index == I_LAST);
  assign finish = wrap && last && !loop_en;
  assign rest = SKIP_RESTS && (rom_q == '0);
  assign accept = note_valid && note_ready;

  always_comb begin
    state_n = state;
    if (stop) state_n = IDLE;
    else if (start) state_n = FETCH;
    else if (state == FETCH) state_n = RUN;
    else if (finish) state_n = DONE;
  end

  // fetch_p: ROM read due next edge; load_p: rom_q holds the step's word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      timer      <= '0;
      index      <= '0;
      fetch_p    <= 1'b0;
      load_p     <= 1'b0;
      note_data  <= '0;
      note_valid <= 1'b0;
      note_index <= '0;
      overrun    <= 1'b0;
      loop_count <= '0;
    end else begin
      state <= state_n;
      if (stop) begin
        timer      <= '0;
        index      <= '0;
        fetch_p    <= 1'b0;
        load_p     <= 1'b0;
        note_valid <= 1'b0;
      end else if (start) begin
        timer      <= '0;
        index      <= '0;
        fetch_p    <= 1'b1;
        load_p     <= 1'b0;
        note_valid <= 1'b0;
        overrun    <= 1'b0;
        loop_count <= '0;
      end else begin
        load_p  <= fetch_p;
        fetch_p <= wrap && !finish;
        if (tick) timer <= wrap ? '0 : timer + TW'(1);
        if (wrap) begin
          if (!last) begin
            index <= index + ADDR_W'(1);
          end else if (loop_en) begin
            index <= '0;
            if (loop_count != 8'hFF) loop_count <= loop_count + 8'd1;
          end
        end
        if (load_p && !rest) begin
          note_data  <= rom_q;
          note_index <= index;
          note_valid <= 1'b1;
          if (note_valid && !note_ready) overrun <= 1'b1;
        end else if (accept) begin
          note_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_beatmap_player.sv
// Bench for beatmap_player: step-level model plus directed timing checks.
// ROM 1111,1010,0000,0101 at four ticks per step.
module tb_beatmap_player;

  localparam int LANES = 4;
  localparam int DEPTH = 4;
  localparam int ADDR_W = 4;
  localparam int T = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic pause = 1'b0;
  logic loop_en = 1'b0;
  logic note_ready = 1'b0;
  logic [LANES-1:0] note_data;
  logic note_valid;
  logic [ADDR_W-1:0] note_index;
  logic playing;
  logic done;
  logic overrun;
  logic [7:0] loop_count;

  int errors = 0;
  int checks = 0;

  beatmap_player #(
    .LANES(LANES),
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .TICKS_PER_STEP(T),
    .SKIP_RESTS(1'b1),
    .INIT_DATA(16'b0101_0000_1010_1111)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .stop(stop),
    .pause(pause),
    .loop_en(loop_en),
    .note_ready(note_ready),
    .note_data(note_data),
    .note_valid(note_valid),
    .note_index(note_index),
    .playing(playing),
    .done(done),
    .overrun(overrun),
    .loop_count(loop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Step-level model: a step lasts T unpaused playing cycles and its
  // note appears two edges after the boundary that selects it.
  int rom [DEPTH] = '{4'b1111, 4'b1010, 4'b0000, 4'b0101};
  int cyc = 0;
  bit m_play, m_done, m_valid, m_ovr;
  int m_data, m_idx, m_loops, m_step, m_elapsed;
  int q_due[$];
  int q_step[$];

  task automatic model_reset();
    m_play = 0; m_done = 0; m_valid = 0; m_ovr = 0;
    m_data = 0; m_idx = 0; m_loops = 0; m_step = 0; m_elapsed = 0;
    q_due.delete(); q_step.delete();
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit pz,
                            input bit lp, input bit rdy);
    bit acc;
    int s;
    if (sp) begin
      m_play = 0; m_done = 0; m_valid = 0; m_step = 0;
      q_due.delete(); q_step.delete();
    end else if (st) begin
      m_play = 1; m_done = 0; m_valid = 0; m_ovr = 0; m_loops = 0;
      m_step = 0; m_elapsed = 0;
      q_due.delete(); q_step.delete();
      q_due.push_back(cyc + 2); q_step.push_back(0);
    end else begin
      acc = m_valid && rdy;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        s = q_step.pop_front();
        void'(q_due.pop_front());
        if (rom[s] != 0) begin
          if (m_valid && !rdy) m_ovr = 1;
          m_valid = 1; m_data = rom[s]; m_idx = s;
        end else if (acc) m_valid = 0;
      end else if (acc) m_valid = 0;
      if (m_play && !pz) begin
        m_elapsed++;
        if (m_elapsed % T == 0) begin
          if (m_step == DEPTH - 1) begin
            if (lp) begin
              m_step = 0;
              if (m_loops < 255) m_loops++;
              q_due.push_back(cyc + 2); q_step.push_back(0);
            end else begin
              m_play = 0; m_done = 1;
            end
          end else begin
            m_step++;
            q_due.push_back(cyc + 2); q_step.push_back(m_step);
          end
        end
      end
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      model_reset();
    end else begin
      cyc++;
      model_edge(start, stop, pause, loop_en, note_ready);
      #1;
      chk("m_valid", 32'(note_valid), 32'(m_valid));
      chk("m_playing", 32'(playing), 32'(m_play));
      chk("m_done", 32'(done), 32'(m_done));
      chk("m_overrun", 32'(overrun), 32'(m_ovr));
      chk("m_loops", 32'(loop_count), 32'(m_loops));
      if (m_valid) begin
        chk("m_data", 32'(note_data), 32'(m_data));
        chk("m_index", 32'(note_index), 32'(m_idx));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    model_reset();
    step(3);
    resetn = 1'b1;
    step(2);
    chk("rst_valid", 32'(note_valid), 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_done", 32'(done), 0);

    // Plain playthrough, consumer always ready.
    note_ready = 1'b1;
    pulse_start();
    step(2);
    chk("e2_valid", 32'(note_valid), 1);
    chk("e2_data", 32'(note_data), 32'b1111);
    chk("e2_index", 32'(note_index), 0);
    step(4);
    chk("e6_data", 32'(note_data), 32'b1010);
    chk("e6_valid", 32'(note_valid), 1);
    step(4);
    chk("e10_rest", 32'(note_valid), 0);
    step(4);
    chk("e14_data", 32'(note_data), 32'b0101);
    chk("e14_index", 32'(note_index), 3);
    step(2);
    chk("e16_done", 32'(done), 1);
    chk("e16_playing", 32'(playing), 0);
    step(2);

    // Two full loops; index sequence 0,1,2,3,0,1,2,3,0.
    loop_en = 1'b1;
    pulse_start();
    step(2);
    for (int k = 0; k <= 8; k++) begin
      if (k % 4 != 2) chk("loop_index", 32'(note_index), 32'(k % 4));
      step(4);
    end
    chk("loop_count", 32'(loop_count), 2);

    // Asynchronous reset mid-run.
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(note_valid), 0);
    chk("arst_data", 32'(note_data), 0);
    chk("arst_playing", 32'(playing), 0);
    chk("arst_loops", 32'(loop_count), 0);
    step(2);
    resetn = 1'b1;
    loop_en = 1'b0;
    step(2);
    chk("post_rst_playing", 32'(playing), 0);

    // Consumer never ready: hold, then overrun.
    note_ready = 1'b0;
    pulse_start();
    step(2);
    chk("nr_e2_data", 32'(note_data), 32'b1111);
    step(3);
    chk("nr_e5_data", 32'(note_data), 32'b1111);
    chk("nr_e5_ovr", 32'(overrun), 0);
    step(1);
    chk("nr_e6_data", 32'(note_data), 32'b1010);
    chk("nr_e6_ovr", 32'(overrun), 1);
    step(4);
    chk("nr_e10_data", 32'(note_data), 32'b1010);
    step(6);
    chk("nr_e16_done", 32'(done), 1);
    chk("nr_e16_valid", 32'(note_valid), 1);
    note_ready = 1'b1;
    step(1);
    chk("nr_accept_done", 32'(note_valid), 0);

    // Pause for five edges during step 1.
    pulse_start();
    step(4);
    pause = 1'b1;
    step(5);
    pause = 1'b0;
    step(5);
    chk("pz_e14_valid", 32'(note_valid), 0);
    step(4);
    chk("pz_e18_valid", 32'(note_valid), 0);
    step(1);
    chk("pz_e19_valid", 32'(note_valid), 1);
    chk("pz_e19_data", 32'(note_data), 32'b0101);
    step(2);
    chk("pz_e21_done", 32'(done), 1);

    // start+stop together, then restart mid-run.
    pulse_start();
    step(9);
    start = 1'b1;
    stop = 1'b1;
    step(1);
    start = 1'b0;
    stop = 1'b0;
    chk("ss_playing", 32'(playing), 0);
    chk("ss_valid", 32'(note_valid), 0);
    pulse_start();
    step(9);
    pulse_start();
    step(2);
    chk("rs_index", 32'(note_index), 0);
    chk("rs_data", 32'(note_data), 32'b1111);
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
